pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 118 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, EX redirect flush, memory-busy freeze (optional HAZARD_PERF_CNT_EN counters).
// Latency 0 (Mealy outputs from state and inputs); mem_busy freezes PC and IF/ID, redirects seen while frozen are held pending.
module pipe_hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ifid_inst,
    input  logic        idex_memread,
    input  logic [4:0]  idex_rd,
    input  logic        ex_redirect,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [1:0]  state_o
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10,
        WAIT  = 2'b11
    } state_t;

    state_t state, state_nxt;
    logic   pending_redirect, pending_nxt;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       uses_rs1, uses_rs2, hazard, redirect;
    logic       pc_we_c, flush_c, bubble_c;
    logic       unused_inst_bits;

    assign opcode           = ifid_inst[6:0];
    assign rs1              = ifid_inst[19:15];
    assign rs2              = ifid_inst[24:20];
    assign unused_inst_bits = ^{ifid_inst[31:25], ifid_inst[14:7]};

    always_comb begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        case (opcode)
            7'b0110011, 7'b1100011, 7'b0100011: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            7'b0010011, 7'b1100111, 7'b0000011: uses_rs1 = 1'b1;
            default: ;
        endcase
    end

    assign hazard   = idex_memread && (idex_rd != 5'd0) &&
                      ((uses_rs1 && (rs1 == idex_rd)) || (uses_rs2 && (rs2 == idex_rd)));
    assign redirect = ex_redirect || pending_redirect;

    // WAIT with memory ready follows the RUN rules, so RUN and WAIT share one arm.
    always_comb begin
        state_nxt   = state;
        pending_nxt = pending_redirect;
        pc_we_c     = 1'b1;
        flush_c     = 1'b0;
        bubble_c    = 1'b0;
        if (mem_busy) begin
            pc_we_c     = 1'b0;
            state_nxt   = WAIT;
            pending_nxt = pending_redirect || ex_redirect;
        end else if (redirect) begin
            flush_c     = 1'b1;
            bubble_c    = 1'b1;
            pending_nxt = 1'b0;
            state_nxt   = FLUSH;
        end else begin
            state_nxt = RUN;
            if ((state == RUN || state == WAIT) && hazard) begin
                pc_we_c   = 1'b0;
                bubble_c  = 1'b1;
                state_nxt = STALL;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= RUN;
            pending_redirect <= 1'b0;
        end else begin
            state            <= state_nxt;
            pending_redirect <= pending_nxt;
        end
    end

    // Reset forces a NOP into both pipeline registers and holds the PC.
    assign pc_we       = !rst && pc_we_c;
    assign ifid_we     = !rst && pc_we_c;
    assign ifid_flush  = rst || flush_c;
    assign idex_bubble = rst || bubble_c;
    assign state_o     = state;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            if (!pc_we)
                stall_cnt <= stall_cnt + 32'd1;
            if (ifid_flush)
                flush_cnt <= flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected outputs queued per step, popped and checked mid-cycle.
module tb_pipe_hazard_ctrl;

    localparam logic [31:0] NOP     = 32'h0000_0013; // addi x0,x0,0
    localparam logic [31:0] ADD_RS1 = 32'h0022_80B3; // add x1,x5,x2
    localparam logic [31:0] ADD_RS2 = 32'h0051_00B3; // add x1,x2,x5
    localparam logic [31:0] ADD_X0  = 32'h0020_00B3; // add x1,x0,x2
    localparam logic [31:0] SW_RS2  = 32'h0051_2023; // sw x5,0(x2)
    localparam logic [31:0] JAL_F5  = 32'h0002_806F; // jal, rs1 field = 5
    localparam logic [31:0] LUI_F5  = 32'h0002_82B7; // lui, rs1 field = 5

    localparam logic [1:0] S_RUN = 2'b00, S_STALL = 2'b01, S_FLUSH = 2'b10, S_WAIT = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ifid_inst;
    logic        idex_memread;
    logic [4:0]  idex_rd;
    logic        ex_redirect;
    logic        mem_busy;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble;
    logic [1:0]  state_o;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    typedef struct packed {
        logic [1:0] st;
        logic       pc;
        logic       ifw;
        logic       fl;
        logic       bb;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    int unsigned m_stall  = 0;
    int unsigned m_flush  = 0;

    pipe_hazard_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .ifid_inst    (ifid_inst),
        .idex_memread (idex_memread),
        .idex_rd      (idex_rd),
        .ex_redirect  (ex_redirect),
        .mem_busy     (mem_busy),
        .pc_we        (pc_we),
        .ifid_we      (ifid_we),
        .ifid_flush   (ifid_flush),
        .idex_bubble  (idex_bubble),
        .state_o      (state_o)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic r, input logic [31:0] inst,
                        input logic mr, input logic [4:0] rd, input logic redir,
                        input logic busy, input logic [1:0] st, input logic pc,
                        input logic fl, input logic bb);
        exp_t e, got;
        rst          = r;
        ifid_inst    = inst;
        idex_memread = mr;
        idex_rd      = rd;
        ex_redirect  = redir;
        mem_busy     = busy;
        if (r) begin
            m_stall = 0;
            m_flush = 0;
        end
        sb.push_back('{st: st, pc: pc, ifw: pc, fl: fl, bb: bb});
        @(negedge clk);
        e   = sb.pop_front();
        got = '{st: state_o, pc: pc_we, ifw: ifid_we, fl: ifid_flush, bb: idex_bubble};
        n_assert++;
        assert (got === e) else begin
            n_fail++;
            $error("FAIL %s: observed st=%b pc_we=%b ifid_we=%b flush=%b bubble=%b, expected st=%b pc_we=%b ifid_we=%b flush=%b bubble=%b",
                   tag, got.st, got.pc, got.ifw, got.fl, got.bb, e.st, e.pc, e.ifw, e.fl, e.bb);
        end
`ifdef HAZARD_PERF_CNT_EN
        n_assert++;
        assert (stall_cnt === m_stall && flush_cnt === m_flush) else begin
            n_fail++;
            $error("FAIL %s_cnt: observed stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                   tag, stall_cnt, flush_cnt, m_stall, m_flush);
        end
`endif
        @(posedge clk);
        if (!r) begin
            if (!pc) m_stall++;
            if (fl)  m_flush++;
        end
        #1;
    endtask

    initial begin
        //   tag          rst inst     mr  rd    rdr busy  state    pc fl bb
        step("reset0",    1, NOP,     0, 5'd0, 0, 0,    S_RUN,   0, 1, 1);
        step("reset1",    1, NOP,     0, 5'd0, 0, 0,    S_RUN,   0, 1, 1);
        step("nop0",      0, NOP,     1, 5'd5, 0, 0,    S_RUN,   1, 0, 0);
        step("nop1",      0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        step("nop2",      0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        // load-use on rs1: one stall cycle, then STALL masks the still-present hazard
        step("lu_rs1",    0, ADD_RS1, 1, 5'd5, 0, 0,    S_RUN,   0, 0, 1);
        step("lu_stall",  0, ADD_RS1, 1, 5'd5, 0, 0,    S_STALL, 1, 0, 0);
        step("lu_run",    0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        step("lu_rs2",    0, ADD_RS2, 1, 5'd5, 0, 0,    S_RUN,   0, 0, 1);
        step("lu_rs2_st", 0, ADD_RS2, 0, 5'd0, 0, 0,    S_STALL, 1, 0, 0);
        step("lu_sw",     0, SW_RS2,  1, 5'd5, 0, 0,    S_RUN,   0, 0, 1);
        step("lu_sw_st",  0, NOP,     0, 5'd0, 0, 0,    S_STALL, 1, 0, 0);
        // no-stall cases
        step("rd0",       0, ADD_RS1, 1, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        step("rd0_x0",    0, ADD_X0,  1, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        step("jal",       0, JAL_F5,  1, 5'd5, 0, 0,    S_RUN,   1, 0, 0);
        step("lui",       0, LUI_F5,  1, 5'd5, 0, 0,    S_RUN,   1, 0, 0);
        step("no_load",   0, ADD_RS1, 0, 5'd5, 0, 0,    S_RUN,   1, 0, 0);
        // redirect beats a concurrent hazard
        step("rd_hz",     0, ADD_RS1, 1, 5'd5, 1, 0,    S_RUN,   1, 1, 1);
        step("rd_flush",  0, ADD_RS1, 1, 5'd5, 0, 0,    S_FLUSH, 1, 0, 0);
        step("rd_run",    0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        // mem_busy 3 cycles with redirect pulse in cycle 2
        step("mb1",       0, NOP,     0, 5'd0, 0, 1,    S_RUN,   0, 0, 0);
        step("mb2",       0, NOP,     0, 5'd0, 1, 1,    S_WAIT,  0, 0, 0);
        step("mb3",       0, NOP,     0, 5'd0, 0, 1,    S_WAIT,  0, 0, 0);
        step("mb_exit",   0, NOP,     0, 5'd0, 0, 0,    S_WAIT,  1, 1, 1);
        step("mb_flush",  0, NOP,     0, 5'd0, 0, 0,    S_FLUSH, 1, 0, 0);
        step("mb_run",    0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        // busy during STALL, then WAIT exit applies RUN rules incl. hazard
        step("sb_hz",     0, ADD_RS1, 1, 5'd5, 0, 0,    S_RUN,   0, 0, 1);
        step("sb_busy",   0, ADD_RS1, 1, 5'd5, 0, 1,    S_STALL, 0, 0, 0);
        step("sb_exit",   0, ADD_RS1, 1, 5'd5, 0, 0,    S_WAIT,  0, 0, 1);
        step("sb_stall",  0, ADD_RS1, 1, 5'd5, 0, 0,    S_STALL, 1, 0, 0);
        step("sb_run",    0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        // redirect during STALL
        step("sr_hz",     0, ADD_RS2, 1, 5'd5, 0, 0,    S_RUN,   0, 0, 1);
        step("sr_redir",  0, ADD_RS2, 1, 5'd5, 1, 0,    S_STALL, 1, 1, 1);
        step("sr_flush",  0, NOP,     0, 5'd0, 0, 0,    S_FLUSH, 1, 0, 0);
        step("sr_run",    0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        // reset during WAIT with a redirect pending
        step("rw_busy",   0, NOP,     0, 5'd0, 1, 1,    S_RUN,   0, 0, 0);
        step("rw_wait",   0, NOP,     0, 5'd0, 0, 1,    S_WAIT,  0, 0, 0);
        step("rw_rst",    1, NOP,     0, 5'd0, 0, 1,    S_RUN,   0, 1, 1);
        step("rw_run",    0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        step("rw_run2",   0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        // reset during STALL
        step("rs_hz",     0, ADD_RS1, 1, 5'd5, 0, 0,    S_RUN,   0, 0, 1);
        step("rs_rst",    1, ADD_RS1, 1, 5'd5, 0, 0,    S_RUN,   0, 1, 1);
        step("rs_run",    0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        step("final",     0, NOP,     0, 5'd0, 0, 0,    S_RUN,   1, 0, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
